ft_tx_ctrl: RTL and testbench

FT600 245-synchronous-FIFO write-side bus master. Sits directly downstream of the FIFO/CPU-to-FTDI selector. It pulls 32-bit words from the selector's read port and drives them onto the FTDI data bus in bounded bursts. A 2-entry skid buffer absorbs upstream read latency and `TXE_N` throttling. No words are dropped or duplicated.

---
 rtl/ft_pkg.sv | 6 +
 rtl/ft_skid_buf.sv | 28 ++
 rtl/ft_tx_ctrl.sv | 73 +++++++
 tb/tb_ft_tx_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_pkg.sv
// ft_pkg: shared types and constants for the FT600 transmit path
package ft_pkg;
    localparam int FT_DATA_WIDTH = 32;
    localparam logic [3:0] FT_BE_ALL = 4'hF;
    typedef enum logic [1:0] {IDLE, TURN, BURST, END} ft_tx_state_t;
endpackage

// File: rtl/ft_skid_buf.sv
// ft_skid_buf: 2-entry register FIFO with registered head, push and pop may coincide
module ft_skid_buf
    import ft_pkg::*;
#(
    parameter int W = FT_DATA_WIDTH
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] tail;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop || (push && count == 2'd0)) head <= (count == 2'd2) ? tail : din;
            if (push && (count == 2'd2 || (count == 2'd1 && !pop))) tail <= din;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/ft_tx_ctrl.sv
// ft_tx_ctrl: FT600 245-sync FIFO write-side burst master with 2-entry skid buffer
module ft_tx_ctrl
    import ft_pkg::*;
#(
    parameter int FT_DATA_WIDTH = ft_pkg::FT_DATA_WIDTH,
    parameter int BURST_LEN     = 1024,
    parameter int CNT_WIDTH     = 11
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [FT_DATA_WIDTH-1:0] src_data_i,
    input  logic                     src_empty_i,
    input  logic                     src_enough_i,
    input  logic                     src_data_incomming_i,
    output logic                     src_re_o,
    input  logic                     ft_txe_n_i,
    output logic                     ft_wr_n_o,
    output logic [FT_DATA_WIDTH-1:0] ft_data_o,
    output logic [3:0]               ft_be_o,
    output logic                     ft_oe_o,
    output logic                     burst_active_o,
    output logic [31:0]              word_cnt_o
);
    ft_tx_state_t state, nxt;
    logic [CNT_WIDTH-1:0] issued;
    logic [1:0] skid_cnt;
    logic inflight, accept, go, done;

    ft_skid_buf #(.W(FT_DATA_WIDTH)) u_skid (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push    (inflight),
        .din     (src_data_i),
        .pop     (accept),
        .head    (ft_data_o),
        .count   (skid_cnt)
    );

    // a pop in the same cycle frees a slot, which keeps reads streaming at one word per cycle
    always_comb begin
        ft_wr_n_o = ~(state == BURST && skid_cnt != 2'd0);
        accept    = ~ft_wr_n_o & ~ft_txe_n_i;
        go        = ~ft_txe_n_i & (src_enough_i | (~src_empty_i & ~src_data_incomming_i));
        src_re_o  = state == BURST && !src_empty_i && skid_cnt != 2'd2
                    && ({1'b0, skid_cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, accept})
                    && issued < CNT_WIDTH'(BURST_LEN);
        done      = skid_cnt == 2'd0 && !inflight
                    && (issued == CNT_WIDTH'(BURST_LEN) || (src_empty_i && !src_data_incomming_i));
        nxt       = state == IDLE  ? (go ? TURN : IDLE) :
                    state == TURN  ? BURST :
                    state == BURST ? (done ? END : BURST) : IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state          <= IDLE;
            issued         <= '0;
            inflight       <= 1'b0;
            ft_oe_o        <= 1'b0;
            ft_be_o        <= '0;
            burst_active_o <= 1'b0;
            word_cnt_o     <= '0;
        end else begin
            state          <= nxt;
            inflight       <= src_re_o;
            issued         <= (state == IDLE && go) ? '0 : issued + CNT_WIDTH'(src_re_o);
            ft_oe_o        <= nxt != IDLE;
            ft_be_o        <= (nxt != IDLE) ? FT_BE_ALL : 4'h0;
            burst_active_o <= nxt != IDLE;
            word_cnt_o     <= word_cnt_o + 32'(accept);
        end
    end
endmodule

// File: tb/tb_ft_tx_ctrl.sv
// tb_ft_tx_ctrl: directed scenarios for the FT600 write-side burst master
module tb_ft_tx_ctrl;
    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [31:0] src_data_i = '0;
    logic        src_empty_i, src_enough_i;
    logic        src_data_incomming_i = 1'b1;
    logic        src_re_o;
    logic        ft_txe_n_i = 1'b1;
    logic        ft_wr_n_o;
    logic [31:0] ft_data_o;
    logic [3:0]  ft_be_o;
    logic        ft_oe_o, burst_active_o;
    logic [31:0] word_cnt_o;

    int n_chk = 0, n_fail = 0;
    int rd_ptr = 0, wr_ptr = 0, cnt_after_rst = 0;
    bit starve = 0, enough_en = 0;

    logic [31:0] acc[$];
    int bsz[$], leads[$];
    int re_cnt = 0, act_cycles = 0, gap_cnt = 0, pad_err = 0;
    int ep_acc = 0, ep_lead = 0;
    bit ep_wr = 0, prev_act = 0;

    assign src_empty_i  = (rd_ptr == wr_ptr) || starve;
    assign src_enough_i = enough_en && (wr_ptr - rd_ptr >= 1024);

    always #5 clk_i = ~clk_i;

    ft_tx_ctrl dut (
        .clk_i                (clk_i),
        .reset_i              (reset_i),
        .src_data_i           (src_data_i),
        .src_empty_i          (src_empty_i),
        .src_enough_i         (src_enough_i),
        .src_data_incomming_i (src_data_incomming_i),
        .src_re_o             (src_re_o),
        .ft_txe_n_i           (ft_txe_n_i),
        .ft_wr_n_o            (ft_wr_n_o),
        .ft_data_o            (ft_data_o),
        .ft_be_o              (ft_be_o),
        .ft_oe_o              (ft_oe_o),
        .burst_active_o       (burst_active_o),
        .word_cnt_o           (word_cnt_o)
    );

    // upstream FIFO model: word value equals its index, one-cycle read latency
    always @(posedge clk_i) begin
        if (src_re_o) begin
            src_data_i <= 32'(rd_ptr);
            rd_ptr     <= rd_ptr + 1;
        end
    end

    // bus monitor: accepted words, per-burst sizes and lead-in cycles
    always @(posedge clk_i) begin
        if (src_re_o) re_cnt++;
        if (ft_oe_o !== burst_active_o || ft_be_o !== (ft_oe_o ? 4'hF : 4'h0)) pad_err++;
        if (burst_active_o) begin
            act_cycles++;
            if (ft_wr_n_o) begin
                gap_cnt++;
                if (!ep_wr) ep_lead++;
            end else ep_wr = 1;
            if (!reset_i && !ft_wr_n_o && !ft_txe_n_i) begin
                acc.push_back(ft_data_o);
                ep_acc++;
            end
        end else if (prev_act) begin
            bsz.push_back(ep_acc);
            leads.push_back(ep_lead);
            ep_acc = 0;
            ep_lead = 0;
            ep_wr = 0;
        end
        prev_act = burst_active_o;
    end

    task automatic wait_done(input int s, input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (acc.size() - s >= n && !burst_active_o) begin
                ok = 1;
                break;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        reset_i = 1;
        repeat (3) @(negedge clk_i);
        n_chk++; if (src_re_o !== 1'b0) begin n_fail++; $display("FAIL reset_re: got %b want 0", src_re_o); end
        n_chk++; if (ft_wr_n_o !== 1'b1) begin n_fail++; $display("FAIL reset_wr_n: got %b want 1", ft_wr_n_o); end
        n_chk++; if (ft_oe_o !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", ft_oe_o); end
        n_chk++; if (ft_be_o !== 4'h0) begin n_fail++; $display("FAIL reset_be: got %h want 0", ft_be_o); end
        n_chk++; if (ft_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", ft_data_o); end
        n_chk++; if (burst_active_o !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", burst_active_o); end
        n_chk++; if (word_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", word_cnt_o); end
        reset_i = 0;
        @(negedge clk_i);
    endtask

    task automatic test_full_burst();
        int s, b, errs;
        bit ok;
        s = acc.size(); b = bsz.size(); errs = 0;
        enough_en = 1; ft_txe_n_i = 0; wr_ptr = 2048;
        wait_done(s, 2048, 6000, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL full_done: got %0d words want 2048", acc.size() - s); end
        n_chk++; if (bsz.size() - b != 2) begin n_fail++; $display("FAIL full_bursts: got %0d want 2", bsz.size() - b); end
        for (int k = 0; k < 2; k++) begin
            n_chk++; if ((bsz.size() > b + k ? bsz[b+k] : -1) != 1024) begin n_fail++; $display("FAIL full_len%0d: got %0d want 1024", k, bsz.size() > b + k ? bsz[b+k] : -1); end
            n_chk++; if ((leads.size() > b + k ? leads[b+k] : -1) != 3) begin n_fail++; $display("FAIL full_lead%0d: got %0d want 3", k, leads.size() > b + k ? leads[b+k] : -1); end
        end
        for (int i = 0; i < 2048; i++) if (acc.size() <= s + i || acc[s+i] !== 32'(i)) errs++;
        n_chk++; if (errs != 0) begin n_fail++; $display("FAIL full_order: got %0d bad words want 0", errs); end
        n_chk++; if (word_cnt_o !== 32'd2048) begin n_fail++; $display("FAIL full_cnt: got %0d want 2048", word_cnt_o); end
        n_chk++; if (ft_oe_o !== 1'b0) begin n_fail++; $display("FAIL full_oe_idle: got %b want 0", ft_oe_o); end
    endtask

    task automatic test_throttle();
        int s, b, r, errs, hold_err;
        bit ok;
        s = acc.size(); b = bsz.size(); errs = 0; hold_err = 0; ok = 0;
        wr_ptr = 3072;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            if (acc.size() - s == 100) begin ok = 1; break; end
        end
        n_chk++; if (!ok) begin n_fail++; $display("FAIL thr_reach: got %0d words want 100", acc.size() - s); end
        ft_txe_n_i = 1; r = re_cnt;
        for (int i = 0; i < 5; i++) begin
            if (ft_wr_n_o !== 1'b0 || ft_data_o !== 32'd2148) hold_err++;
            @(negedge clk_i);
        end
        n_chk++; if (hold_err != 0) begin n_fail++; $display("FAIL thr_hold: got %0d bad cycles want 0 (data %0d)", hold_err, ft_data_o); end
        n_chk++; if (re_cnt - r != 0) begin n_fail++; $display("FAIL thr_re_stop: got %0d reads want 0", re_cnt - r); end
        n_chk++; if (acc.size() - s != 100) begin n_fail++; $display("FAIL thr_no_acc: got %0d want 100", acc.size() - s); end
        n_chk++; if (word_cnt_o !== 32'd2148) begin n_fail++; $display("FAIL thr_cnt_hold: got %0d want 2148", word_cnt_o); end
        ft_txe_n_i = 0;
        wait_done(s, 1024, 4000, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL thr_done: got %0d words want 1024", acc.size() - s); end
        for (int i = 0; i < 1024; i++) if (acc.size() <= s + i || acc[s+i] !== 32'(2048 + i)) errs++;
        n_chk++; if (errs != 0 || acc.size() - s != 1024) begin n_fail++; $display("FAIL thr_order: got %0d bad of %0d want 0 of 1024", errs, acc.size() - s); end
        n_chk++; if ((bsz.size() > b ? bsz[b] : -1) != 1024) begin n_fail++; $display("FAIL thr_len: got %0d want 1024", bsz.size() > b ? bsz[b] : -1); end
        n_chk++; if (word_cnt_o !== 32'd3072) begin n_fail++; $display("FAIL thr_cnt: got %0d want 3072", word_cnt_o); end
    endtask

    task automatic test_tail_flush();
        int s, b, errs;
        bit ok;
        s = acc.size(); b = bsz.size(); errs = 0;
        src_data_incomming_i = 1; wr_ptr = 3079;
        repeat (6) @(negedge clk_i);
        n_chk++; if (burst_active_o !== 1'b0) begin n_fail++; $display("FAIL tail_wait: got %b want 0", burst_active_o); end
        src_data_incomming_i = 0;
        wait_done(s, 7, 200, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL tail_done: got %0d words want 7", acc.size() - s); end
        n_chk++; if (bsz.size() - b != 1 || (bsz.size() > b ? bsz[b] : -1) != 7) begin n_fail++; $display("FAIL tail_len: got %0d bursts want 1 of 7", bsz.size() - b); end
        for (int i = 0; i < 7; i++) if (acc.size() <= s + i || acc[s+i] !== 32'(3072 + i)) errs++;
        n_chk++; if (errs != 0) begin n_fail++; $display("FAIL tail_order: got %0d bad want 0", errs); end
        n_chk++; if (word_cnt_o !== 32'd3079) begin n_fail++; $display("FAIL tail_cnt: got %0d want 3079", word_cnt_o); end
    endtask

    task automatic test_starvation();
        int s, b, g, errs;
        bit ok;
        s = acc.size(); b = bsz.size(); g = gap_cnt; errs = 0; ok = 0;
        src_data_incomming_i = 1; wr_ptr = 4103;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk_i);
            if (i % 3 == 0) starve = ~starve;
            if (acc.size() - s >= 1024 && !burst_active_o) begin ok = 1; break; end
        end
        starve = 0;
        @(negedge clk_i);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL starve_done: got %0d words want 1024", acc.size() - s); end
        n_chk++; if (bsz.size() - b != 1 || (bsz.size() > b ? bsz[b] : -1) != 1024) begin n_fail++; $display("FAIL starve_len: got %0d bursts want 1 of 1024", bsz.size() - b); end
        for (int i = 0; i < 1024; i++) if (acc.size() <= s + i || acc[s+i] !== 32'(3079 + i)) errs++;
        n_chk++; if (errs != 0) begin n_fail++; $display("FAIL starve_order: got %0d bad want 0", errs); end
        n_chk++; if (gap_cnt - g <= 5) begin n_fail++; $display("FAIL starve_gaps: got %0d want >5", gap_cnt - g); end
        n_chk++; if (word_cnt_o !== 32'd4103) begin n_fail++; $display("FAIL starve_cnt: got %0d want 4103", word_cnt_o); end
    endtask

    task automatic test_reset_mid_burst();
        int s, b, r0, n, errs;
        bit ok;
        s = acc.size(); errs = 0; ok = 0;
        wr_ptr = 5127;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            if (acc.size() - s == 500) begin ok = 1; break; end
        end
        n_chk++; if (!ok) begin n_fail++; $display("FAIL rst_reach: got %0d words want 500", acc.size() - s); end
        reset_i = 1;
        @(negedge clk_i);
        n_chk++; if (ft_wr_n_o !== 1'b1) begin n_fail++; $display("FAIL rst_wr_n: got %b want 1", ft_wr_n_o); end
        n_chk++; if (ft_oe_o !== 1'b0) begin n_fail++; $display("FAIL rst_oe: got %b want 0", ft_oe_o); end
        n_chk++; if (word_cnt_o !== 32'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", word_cnt_o); end
        reset_i = 0; r0 = rd_ptr; n = 5127 - r0;
        repeat (4) @(negedge clk_i);
        n_chk++; if (burst_active_o !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got %b want 0", burst_active_o); end
        s = acc.size(); b = bsz.size();
        src_data_incomming_i = 0;
        wait_done(s, n, 3000, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL rst_done: got %0d words want %0d", acc.size() - s, n); end
        for (int i = 0; i < n; i++) if (acc.size() <= s + i || acc[s+i] !== 32'(r0 + i)) errs++;
        n_chk++; if (errs != 0) begin n_fail++; $display("FAIL rst_order: got %0d bad want 0", errs); end
        n_chk++; if ((bsz.size() > b ? bsz[b] : -1) != n) begin n_fail++; $display("FAIL rst_len: got %0d want %0d", bsz.size() > b ? bsz[b] : -1, n); end
        n_chk++; if (word_cnt_o !== 32'(n)) begin n_fail++; $display("FAIL rst_cnt2: got %0d want %0d", word_cnt_o, n); end
        cnt_after_rst = n;
        src_data_incomming_i = 1;
    endtask

    task automatic test_idle_block();
        int r, a;
        ft_txe_n_i = 1; enough_en = 1; wr_ptr = 6151;
        r = re_cnt; a = act_cycles;
        repeat (30) @(negedge clk_i);
        n_chk++; if (src_enough_i !== 1'b1) begin n_fail++; $display("FAIL idle_enough: got %b want 1", src_enough_i); end
        n_chk++; if (re_cnt - r != 0) begin n_fail++; $display("FAIL idle_re: got %0d reads want 0", re_cnt - r); end
        n_chk++; if (act_cycles - a != 0) begin n_fail++; $display("FAIL idle_active: got %0d cycles want 0", act_cycles - a); end
        n_chk++; if (word_cnt_o !== 32'(cnt_after_rst)) begin n_fail++; $display("FAIL idle_cnt: got %0d want %0d", word_cnt_o, cnt_after_rst); end
        n_chk++; if (pad_err != 0) begin n_fail++; $display("FAIL pad_consistency: got %0d bad cycles want 0", pad_err); end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_throttle();
        test_tail_flush();
        test_starvation();
        test_reset_mid_burst();
        test_idle_block();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
